// File: rtl/fixp_dec_display_if.sv
`default_nettype none
// ============================================================================
// Module   : fixp_dec_display_if
// Brief    : Request/FIFO handshake bundle between the sample FIFO and the
//            fixed-point to decimal display converter.
// Revision : 1.0  initial release
// ============================================================================
interface fixp_dec_display_if #(
  parameter int INT_W  = 2,
  parameter int FRAC_W = 16
) ();
  logic                    next;
  logic                    fifo_ready;
  logic [INT_W+FRAC_W-1:0] fifo_q;
  logic [2:0]              fifo_usedw;
  logic                    fifo_rd;
  logic                    busy;
  logic                    done;

  modport master (
    output next, fifo_ready, fifo_q, fifo_usedw,
    input  fifo_rd, busy, done
  );

  modport slave (
    input  next, fifo_ready, fifo_q, fifo_usedw,
    output fifo_rd, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/fixp_dec_display.sv
`default_nettype none
// ============================================================================
// Module   : fixp_dec_display
// Brief    : Pops one unsigned fixed-point sample and shows it on 7-segment
//            digits (hex integer part, decimal fraction). Optional rounding
//            stage compiled in with macro FIXP_DEC_ROUND_EN.
// Revision : 1.0  initial release
// ============================================================================
module fixp_dec_display #(
  parameter int INT_W       = 2,
  parameter int FRAC_W      = 16,
  parameter int FRAC_DIGITS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  fixp_dec_display_if.slave        bus,
  output logic                     round_sat,
  output logic [6:0]               seg_int,
  output logic [7*FRAC_DIGITS-1:0] seg_frac,
  output logic [6:0]               seg_usedw
);

  localparam int c_cnt_w = $clog2(FRAC_DIGITS + 1);
  localparam int c_bcd_w = 4 * FRAC_DIGITS;
  localparam logic [c_cnt_w-1:0] c_last_digit = c_cnt_w'(FRAC_DIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POP   = 3'd1,
    S_WAIT  = 3'd2,
    S_CONV  = 3'd3,
`ifdef FIXP_DEC_ROUND_EN
    S_ROUND = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [INT_W-1:0]     int_q, int_d;
  logic [FRAC_W-1:0]    frac_q, frac_d;
  logic [c_bcd_w-1:0]   bcd_q, bcd_d;
  logic [c_cnt_w-1:0]   cnt_q, cnt_d;
  logic [INT_W-1:0]     disp_int_q, disp_int_d;
  logic [c_bcd_w-1:0]   disp_bcd_q, disp_bcd_d;
  logic                 round_sat_q, round_sat_d;
  logic                 round_sat_w;
  logic                 commit_w;
  logic [FRAC_W+3:0]    prod_w;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // frac*10 as (frac<<3)+(frac<<1); the top nibble is the next decimal digit
  assign prod_w = ({4'b0000, frac_q} << 3) + ({4'b0000, frac_q} << 1);

  always_comb begin
    state_d     = state_q;
    int_d       = int_q;
    frac_d      = frac_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    round_sat_w = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.next && bus.fifo_ready) state_d = S_POP;
      end
      S_POP: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        int_d   = bus.fifo_q[INT_W+FRAC_W-1:FRAC_W];
        frac_d  = bus.fifo_q[FRAC_W-1:0];
        cnt_d   = '0;
        state_d = S_CONV;
      end
      S_CONV: begin
        for (int i = 0; i < FRAC_DIGITS; i++) begin
          if (cnt_q == c_cnt_w'(i)) bcd_d[4*(FRAC_DIGITS-1-i) +: 4] = prod_w[FRAC_W+3:FRAC_W];
        end
        frac_d = prod_w[FRAC_W-1:0];
        cnt_d  = cnt_q + c_cnt_w'(1);
        if (cnt_q == c_last_digit) begin
`ifdef FIXP_DEC_ROUND_EN
          state_d = S_ROUND;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef FIXP_DEC_ROUND_EN
      S_ROUND: begin : round_blk
        logic       carry;
        logic [3:0] dig;
        carry = (prod_w[FRAC_W+3:FRAC_W] >= 4'd5);
        dig   = 4'd0;
        // decimal ripple increment starting at the least significant digit
        for (int i = 0; i < FRAC_DIGITS; i++) begin
          dig = bcd_q[4*i +: 4];
          if (carry) begin
            if (dig == 4'd9) begin
              bcd_d[4*i +: 4] = 4'd0;
            end else begin
              bcd_d[4*i +: 4] = dig + 4'd1;
              carry = 1'b0;
            end
          end
        end
        if (carry) begin
          if (int_q == {INT_W{1'b1}}) begin
            int_d       = {INT_W{1'b1}};
            bcd_d       = {FRAC_DIGITS{4'd9}};
            round_sat_w = 1'b1;
          end else begin
            int_d = int_q + INT_W'(1);
          end
        end
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // display registers only change on the edge that enters DONE
  always_comb begin
    commit_w    = (state_d == S_DONE);
    disp_int_d  = disp_int_q;
    disp_bcd_d  = disp_bcd_q;
    round_sat_d = round_sat_q;
    if (commit_w) begin
      disp_int_d  = int_d;
      disp_bcd_d  = bcd_d;
      round_sat_d = round_sat_w;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      int_q       <= '0;
      frac_q      <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      disp_int_q  <= '0;
      disp_bcd_q  <= '0;
      round_sat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      int_q       <= int_d;
      frac_q      <= frac_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      disp_int_q  <= disp_int_d;
      disp_bcd_q  <= disp_bcd_d;
      round_sat_q <= round_sat_d;
    end
  end

  assign bus.fifo_rd = (state_q == S_POP);
  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = (state_q == S_DONE);
  assign round_sat   = round_sat_q;
  assign seg_int     = hex7(4'(disp_int_q));
  assign seg_usedw   = hex7({1'b0, bus.fifo_usedw});

  generate
    for (genvar g = 0; g < FRAC_DIGITS; g++) begin : g_seg_frac
      assign seg_frac[7*g +: 7] = hex7(disp_bcd_q[4*g +: 4]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/fixp_dec_display.md
FIXP_DEC_DISPLAY -- requirements
Module: fixp_dec_display

Interface
REQ-001 SHALL have parameter INT_W, default 2: integer bits of the fixed-point sample, legal range 1..4.
REQ-002 SHALL have parameter FRAC_W, default 16: fraction bits of the sample, legal range 4..24.
REQ-003 SHALL have parameter FRAC_DIGITS, default 3: decimal fraction digits produced, legal range 1..6.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port next, input, 1 bit: request to fetch and convert the next FIFO sample.
REQ-007 SHALL have port fifo_ready, input, 1 bit: the FIFO holds at least one sample.
REQ-008 SHALL have port fifo_q, input, INT_W+FRAC_W bits: FIFO data, valid one cycle after fifo_rd.
REQ-009 SHALL have port fifo_usedw, input, 3 bits: FIFO fill count.
REQ-010 SHALL have port fifo_rd, output, 1 bit: one-cycle FIFO pop strobe.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when new display values are committed.
REQ-013 SHALL have port round_sat, output, 1 bit: the last committed result saturated.
REQ-014 SHALL have port seg_int, output, 7 bits: active-low {g..a} hex digit of the integer part.
REQ-015 SHALL have port seg_frac, output, 7*FRAC_DIGITS bits: active-low decimal digits, most significant digit in the top 7 bits.
REQ-016 SHALL have port seg_usedw, output, 7 bits: active-low hex digit of {1'b0, fifo_usedw}, combinational.

Function
REQ-017 SHALL implement FSM IDLE, POP, WAIT, CONV, ROUND (ROUND_EN only) and DONE.
REQ-018 IDLE: SHALL go to POP when next=1 and fifo_ready=1 are sampled together; otherwise SHALL stay in IDLE.
REQ-019 POP: SHALL drive fifo_rd=1 for exactly this one cycle and SHALL go to WAIT.
REQ-020 WAIT: SHALL load int_r = fifo_q[INT_W+FRAC_W-1:FRAC_W], frac_r = fifo_q[FRAC_W-1:0] and digit counter = 0, then go to CONV.
REQ-021 CONV: each cycle SHALL form p = frac_r*10 in FRAC_W+4 bits, store digit p[FRAC_W+3:FRAC_W] into the working BCD slot (MSD first) and set frac_r = p[FRAC_W-1:0].
REQ-022 CONV: SHALL exit after FRAC_DIGITS cycles, to ROUND if compiled in, otherwise to DONE.
REQ-023 On entry to DONE, SHALL commit the working int/BCD values to the display registers and update round_sat; done SHALL be 1 for that one DONE cycle; the next state SHALL be IDLE.
REQ-024 Latency without ROUND_EN: done SHALL be high in cycle 3+FRAC_DIGITS, counting the accepting edge as cycle 0 (6 for the defaults); with ROUND_EN it SHALL be one cycle later.
REQ-025 Display outputs SHALL hold their previous values throughout the conversion; no partial results SHALL be visible.
REQ-026 next while busy=1 SHALL be ignored, not queued; next held high SHALL start one conversion per return to IDLE.
REQ-027 Without ROUND_EN, digits SHALL be truncated and round_sat SHALL be 0.

Reset
REQ-028 rst=0 SHALL immediately force IDLE, fifo_rd=0, busy=0, done=0, round_sat=0, and clear all working and display registers to 0.
REQ-029 After reset, seg_int and every seg_frac digit SHALL show '0' (7'b1000000).
REQ-030 Reset mid-conversion SHALL abort it; a sample already popped is discarded, and no done pulse SHALL be generated.

Configuration
REQ-031 Macro FIXP_DEC_ROUND_EN SHALL compile in the ROUND state.
REQ-032 With FIXP_DEC_ROUND_EN defined, ROUND SHALL compute one guard digit as in REQ-021.
REQ-033 With FIXP_DEC_ROUND_EN defined and guard digit >= 5, SHALL BCD-increment the fraction with a ripple carry into int_r.
REQ-034 With FIXP_DEC_ROUND_EN defined, if the carry overflows int_r at 2^INT_W-1, the result SHALL saturate to int = 2^INT_W-1 and all fraction digits = 9, with round_sat=1.
REQ-035 Without FIXP_DEC_ROUND_EN, the ROUND state SHALL be absent (truncating behaviour, REQ-027).

Verification (INT_W=2, FRAC_W=16, FRAC_DIGITS=3)
REQ-036 fifo_q=18'h18000 with next pulse -> one fifo_rd pulse, done in cycle 6, display shows 1.500.
REQ-037 fifo_q=18'h24000 -> display 2.250; seg_frac = {'2','5','0'}.
REQ-038 fifo_q=18'h1FFFF: without macro -> 1.999, round_sat=0; with macro -> 2.000, round_sat=0.
REQ-039 fifo_q=18'h3FFFF with FIXP_DEC_ROUND_EN -> display 3.999, round_sat=1.
REQ-040 next with fifo_ready=0 -> no fifo_rd, busy stays 0, display unchanged.
REQ-041 next during CONV -> ignored; rst low during CONV -> display shows 0.000, busy=0, no done pulse.
